// File: rtl/dac_pkg.sv
// Shared constants for the DAC frame scheduler: SPI word layout, DAC command
// bytes and the one-hot state encoding.
package dac_pkg;

  localparam int CMD_W  = 8;
  localparam int DATA_W = 16;
  localparam int WORD_W = CMD_W + DATA_W;

  localparam logic [CMD_W-1:0]  CMD_INIT          = 8'h00;
  localparam logic [DATA_W-1:0] DATA_INIT         = 16'h0000;
  localparam logic [CMD_W-1:0]  CMD_LOAD_A        = 8'h10;
  localparam logic [CMD_W-1:0]  CMD_LOAD_B_UPDATE = 8'h24;

  // The transmitter only samples o_Send on alternate cycles, so two is the floor.
  localparam int SEND_HOLD = 2;

  typedef enum logic [6:0] {
    INIT_SEND = 7'b0000001,
    INIT_WAIT = 7'b0000010,
    IDLE      = 7'b0000100,
    A_SEND    = 7'b0001000,
    A_WAIT    = 7'b0010000,
    B_SEND    = 7'b0100000,
    B_WAIT    = 7'b1000000
  } state_e;

endpackage

// File: rtl/dac_frame_scheduler.sv
// Turns each sample strobe into a two-word SPI frame (load A, then load B and
// update both outputs) after a one-time configuration word, queuing one frame.
module dac_frame_scheduler
  import dac_pkg::*;
(
  input  logic              i_Clock,
  input  logic              i_Reset_N,
  input  logic              i_Sample_Strobe,
  input  logic [DATA_W-1:0] i_Channel_A,
  input  logic [DATA_W-1:0] i_Channel_B,
  output logic [WORD_W-1:0] o_Data,
  output logic              o_Send,
  input  logic              i_Ready,
  output logic              o_Busy,
  output logic              o_Overrun,
  input  logic              i_Clear_Overrun
);

  localparam logic [1:0] HOLD_LAST = 2'(SEND_HOLD);

  state_e              state_q, state_d;
  logic [1:0]          hold_q, hold_d;
  logic                send_q, send_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                pending_q, pending_d;
  logic                overrun_q, overrun_d;
  logic [DATA_W-1:0]   hold_a_q, hold_a_d, hold_b_q, hold_b_d;
  logic [DATA_W-1:0]   pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic                launch, take, fresh, ovr_set;

  always_comb begin
    // NOTE: every variable gets its default first so no path can infer a latch.
    state_d   = state_q;
    hold_d    = hold_q;
    send_d    = send_q;
    data_d    = data_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    hold_a_d  = hold_a_q;
    hold_b_d  = hold_b_q;
    pend_a_d  = pend_a_q;
    pend_b_d  = pend_b_q;
    launch    = 1'b0;
    take      = 1'b0;
    fresh     = 1'b0;
    ovr_set   = 1'b0;

    case (state_q)
      INIT_SEND, A_SEND, B_SEND: begin
        if (send_q) begin
          if (hold_q == HOLD_LAST) begin
            // hold_q stays non-zero so the first WAIT cycle ignores i_Ready.
            send_d  = 1'b0;
            state_d = (state_q == INIT_SEND) ? INIT_WAIT :
                      (state_q == A_SEND)    ? A_WAIT : B_WAIT;
          end else begin
            hold_d = hold_q + 2'd1;
          end
        end else if (i_Ready) begin
          launch = 1'b1;
        end
      end
      INIT_WAIT, A_WAIT, B_WAIT: begin
        if (hold_q != 2'd0) begin
          hold_d = 2'd0;
        end else if (i_Ready) begin
          if (state_q == A_WAIT) begin
            state_d = B_SEND;
            launch  = 1'b1;
          end else if (state_q == B_WAIT && pending_q) begin
            state_d = A_SEND;
            take    = 1'b1;
            launch  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
        // A frame queued during init is served here rather than stranded.
        if (pending_q) begin
          state_d = A_SEND;
          take    = 1'b1;
          launch  = i_Ready;
        end else if (i_Sample_Strobe) begin
          state_d = A_SEND;
          fresh   = 1'b1;
          launch  = i_Ready;
        end
      end
      default: state_d = INIT_SEND;
    endcase

    if (launch) begin
      send_d = 1'b1;
      hold_d = 2'd1;
    end
    if (fresh) begin
      hold_a_d = i_Channel_A;
      hold_b_d = i_Channel_B;
    end
    if (take) begin
      hold_a_d  = pend_a_q;
      hold_b_d  = pend_b_q;
      pending_d = 1'b0;
    end

    // A strobe that cannot start a frame directly is queued, or dropped if
    // the queue slot is still occupied.
    if (i_Sample_Strobe && !fresh) begin
      if (!pending_q || take) begin
        pending_d = 1'b1;
        pend_a_d  = i_Channel_A;
        pend_b_d  = i_Channel_B;
      end else begin
        ovr_set = 1'b1;
      end
    end

    if (i_Clear_Overrun) overrun_d = 1'b0;
    if (ovr_set)         overrun_d = 1'b1;

    if (state_d != state_q && (state_d == A_SEND || state_d == B_SEND)) begin
      data_d = (state_d == A_SEND) ? {CMD_LOAD_A, hold_a_d}
                                   : {CMD_LOAD_B_UPDATE, hold_b_d};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the same pre-edge values regardless of evaluation order.
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state_q   <= INIT_SEND;
      hold_q    <= 2'd0;
      send_q    <= 1'b0;
      data_q    <= {CMD_INIT, DATA_INIT};
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      // NOTE: the sample registers are few and cheap, so they are reset too;
      // a frame sent after reset can never carry stale data.
      hold_a_q  <= '0;
      hold_b_q  <= '0;
      pend_a_q  <= '0;
      pend_b_q  <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      send_q    <= send_d;
      data_q    <= data_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      hold_a_q  <= hold_a_d;
      hold_b_q  <= hold_b_d;
      pend_a_q  <= pend_a_d;
      pend_b_q  <= pend_b_d;
    end
  end

  assign o_Data    = data_q;
  assign o_Send    = send_q;
  assign o_Busy    = (state_q != IDLE);
  assign o_Overrun = overrun_q;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Directed bench for dac_frame_scheduler with a simple SPI transmitter model
// and a monitor that logs each sent word with its o_Send length.
module tb_dac_frame_scheduler;

  localparam int WORD_T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strobe;
  logic [15:0] ch_a, ch_b;
  logic [23:0] o_data;
  logic        o_send;
  logic        i_ready;
  logic        o_busy;
  logic        o_overrun;
  logic        clr;

  logic        tx_ready;
  int          tx_cnt;
  logic        ready_block;

  logic [23:0] words[$];
  int          lens[$];
  logic [23:0] cur_word;
  int          run;
  logic        busy_dropped;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign i_ready = tx_ready & ~ready_block;

  dac_frame_scheduler dut (
    .i_Clock         (clk),
    .i_Reset_N       (rst_n),
    .i_Sample_Strobe (strobe),
    .i_Channel_A     (ch_a),
    .i_Channel_B     (ch_b),
    .o_Data          (o_data),
    .o_Send          (o_send),
    .i_Ready         (i_ready),
    .o_Busy          (o_busy),
    .o_Overrun       (o_overrun),
    .i_Clear_Overrun (clr)
  );

  // Transmitter: accepts a word, drops ready for WORD_T cycles, then recovers.
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_ready = 1'b1;
      tx_cnt   = 0;
    end else if (tx_cnt > 0) begin
      tx_cnt = tx_cnt - 1;
      if (tx_cnt == 0) tx_ready = 1'b1;
    end else if (o_send && i_ready) begin
      tx_ready = 1'b0;
      tx_cnt   = WORD_T;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else begin
      if (!o_busy) busy_dropped = 1'b1;
      if (o_send) begin
        if (run == 0) cur_word = o_data;
        run = run + 1;
      end else if (run > 0) begin
        words.push_back(cur_word);
        lens.push_back(run);
        run = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_strobe(input logic [15:0] a, input logic [15:0] b);
    strobe = 1'b1;
    ch_a   = a;
    ch_b   = b;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_word(input string tag, input logic [23:0] w);
    int n = 0;
    logic [23:0] got;
    int len;
    while (words.size() == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_avail"}, 32'(words.size() != 0), 32'd1);
    if (words.size() != 0) begin
      got = words.pop_front();
      len = lens.pop_front();
      check({tag, "_word"}, {8'h00, got}, {8'h00, w});
      check({tag, "_len"}, 32'(len), 32'd2);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (o_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    strobe      = 1'b0;
    ch_a        = '0;
    ch_b        = '0;
    clr         = 1'b0;
    ready_block = 1'b0;
    busy_dropped = 1'b0;
    tx_ready    = 1'b1;
    tx_cnt      = 0;
    run         = 0;
    cur_word    = '0;

    // Reset values
    gap(3);
    check("rst_send", {31'd0, o_send}, 32'd0);
    check("rst_data", {8'h00, o_data}, 32'h0);
    check("rst_busy", {31'd0, o_busy}, 32'd1);
    check("rst_ovr",  {31'd0, o_overrun}, 32'd0);
    rst_n = 1'b1;

    // Init word, then quiet until a strobe
    expect_word("init", 24'h000000);
    wait_idle("init_idle");
    gap(20);
    check("init_quiet", 32'(words.size()), 32'd0);

    // Single frame with strobe-to-send latency
    do_strobe(16'h1234, 16'hABCD);
    check("lat_send", {31'd0, o_send}, 32'd1);
    check("lat_data", {8'h00, o_data}, 32'h101234);
    check("lat_busy", {31'd0, o_busy}, 32'd1);
    expect_word("f1_a", 24'h101234);
    expect_word("f1_b", 24'h24ABCD);
    wait_idle("f1_idle");

    // Second strobe mid-frame runs back-to-back
    do_strobe(16'h1111, 16'h2222);
    busy_dropped = 1'b0;
    gap(5);
    do_strobe(16'h0001, 16'h0002);
    expect_word("f2_a", 24'h101111);
    expect_word("f2_b", 24'h242222);
    expect_word("f3_a", 24'h100001);
    check("f3_nogap", {31'd0, busy_dropped}, 32'd0);
    expect_word("f3_b", 24'h240002);
    check("f3_ovr", {31'd0, o_overrun}, 32'd0);
    wait_idle("f3_idle");

    // Three strobes in one frame: third dropped, overrun sticky
    do_strobe(16'h0A0A, 16'h0B0B);
    gap(2);
    do_strobe(16'h0C0C, 16'h0D0D);
    gap(2);
    check("ovr_pre", {31'd0, o_overrun}, 32'd0);
    do_strobe(16'hEEEE, 16'hFFFF);
    check("ovr_set", {31'd0, o_overrun}, 32'd1);
    expect_word("o1_a", 24'h100A0A);
    expect_word("o1_b", 24'h240B0B);
    expect_word("o2_a", 24'h100C0C);
    expect_word("o2_b", 24'h240D0D);
    wait_idle("ovr_idle");
    gap(20);
    check("ovr_dropped", 32'(words.size()), 32'd0);
    check("ovr_sticky", {31'd0, o_overrun}, 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("ovr_clr", {31'd0, o_overrun}, 32'd0);

    // Clear coinciding with a new overrun: set wins
    do_strobe(16'h3001, 16'h3002);
    gap(2);
    do_strobe(16'h3003, 16'h3004);
    gap(2);
    clr = 1'b1;
    do_strobe(16'h3005, 16'h3006);
    clr = 1'b0;
    check("ovr_set_wins", {31'd0, o_overrun}, 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("ovr_clr2", {31'd0, o_overrun}, 32'd0);
    expect_word("c1_a", 24'h103001);
    expect_word("c1_b", 24'h243002);
    expect_word("c2_a", 24'h103003);
    expect_word("c2_b", 24'h243004);
    wait_idle("c_idle");

    // Ready held low in A_SEND
    ready_block = 1'b1;
    do_strobe(16'h5555, 16'h6666);
    begin
      int highs = 0;
      for (int i = 0; i < 40; i++) begin
        if (o_send) highs++;
        @(negedge clk);
      end
      check("rdy_blocked", 32'(highs), 32'd0);
    end
    ready_block = 1'b0;
    @(negedge clk);
    check("rdy_send", {31'd0, o_send}, 32'd1);
    check("rdy_data", {8'h00, o_data}, 32'h105555);
    expect_word("r_a", 24'h105555);
    expect_word("r_b", 24'h246666);
    wait_idle("r_idle");

    // Asynchronous reset during B_WAIT with a pending frame and overrun set
    do_strobe(16'h7777, 16'h8888);
    gap(2);
    do_strobe(16'h7001, 16'h7002);
    gap(2);
    do_strobe(16'h7003, 16'h7004);
    check("ar_ovr_pre", {31'd0, o_overrun}, 32'd1);
    expect_word("ar_a", 24'h107777);
    expect_word("ar_b", 24'h248888);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_send", {31'd0, o_send}, 32'd0);
    check("ar_data", {8'h00, o_data}, 32'h0);
    check("ar_ovr",  {31'd0, o_overrun}, 32'd0);
    check("ar_busy", {31'd0, o_busy}, 32'd1);
    words.delete();
    lens.delete();
    gap(3);
    rst_n = 1'b1;
    expect_word("ar_init", 24'h000000);
    wait_idle("ar_idle");
    gap(20);
    check("ar_no_pending", 32'(words.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
